// File: rtl/sum_normalizer46_if.sv
// Handshake bundle for sum_normalizer46: the upstream sum channel and the downstream normalized-result channel.
interface sum_normalizer46_if #(
  parameter int SUM_W  = 46,
  parameter int MANT_W = 24,
  parameter int CNT_W  = 6
);
  logic              in_valid;
  logic              in_ready;
  logic [SUM_W-1:0]  sum_in;
  logic              out_valid;
  logic              out_ready;
  logic [MANT_W-1:0] norm_mant;
  logic              guard;
  logic              sticky;
  logic [CNT_W-1:0]  lz_cnt;
  logic              zero;

  modport master (
    output in_valid, sum_in, out_ready,
    input  in_ready, out_valid, norm_mant, guard, sticky, lz_cnt, zero
  );

  modport slave (
    input  in_valid, sum_in, out_ready,
    output in_ready, out_valid, norm_mant, guard, sticky, lz_cnt, zero
  );
endinterface

// File: rtl/sum_normalizer46.sv
// Iterative left-normalizer for the adder sum: shifts until the MSB is set, reports mantissa/guard/sticky/shift count.
// Optional FAST_NORM_SHIFT4_EN adds a 4-bit skip when the top nibble is zero.
module sum_normalizer46 #(
  parameter int SUM_W  = 46,
  parameter int MANT_W = 24,
  parameter int CNT_W  = 6
) (
  input  logic             clk,
  input  logic             rst,
  sum_normalizer46_if.slave bus
);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state_q, state_d;
  logic [SUM_W-1:0] work_q, work_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             done;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      work_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    work_d  = work_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          work_d  = bus.sum_in;
          cnt_d   = '0;
          state_d = (bus.sum_in == '0) ? DONE : SHIFT;
        end
      end
      SHIFT: begin
        // A nonzero value can never shift to zero, so this loop always terminates.
        if (work_q[SUM_W-1]) begin
          state_d = DONE;
        end
`ifdef FAST_NORM_SHIFT4_EN
        else if (work_q[SUM_W-1 -: 4] == '0) begin
          work_d = work_q << 4;
          cnt_d  = cnt_q + CNT_W'(4);
        end
`endif
        else begin
          work_d = work_q << 1;
          cnt_d  = cnt_q + CNT_W'(1);
        end
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign done          = (state_q == DONE);
  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = done;

  // Only a zero input reaches DONE with an all-zero work register.
  assign bus.norm_mant = done ? work_q[SUM_W-1 -: MANT_W] : '0;
  assign bus.guard     = done & work_q[SUM_W-1-MANT_W];
  assign bus.sticky    = done & (|work_q[SUM_W-2-MANT_W:0]);
  assign bus.lz_cnt    = done ? cnt_q : '0;
  assign bus.zero      = done & (work_q == '0);
endmodule

// File: tb/tb_sum_normalizer46.sv
// Directed self-checking bench for sum_normalizer46 (default parameters).
module tb_sum_normalizer46;
  logic clk;
  logic rst;
  int   checks;
  int   errors;

  sum_normalizer46_if #(.SUM_W(46), .MANT_W(24), .CNT_W(6)) bus ();

  sum_normalizer46 #(.SUM_W(46), .MANT_W(24), .CNT_W(6)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Edges after the accept edge until out_valid is seen; zero inputs go straight to DONE.
  function automatic int exp_lat(input int lz, input bit is_zero);
    if (is_zero) return 0;
`ifdef FAST_NORM_SHIFT4_EN
    return lz / 4 + lz % 4 + 1;
`else
    return lz + 1;
`endif
  endfunction

  // Accepts one sum, waits (bounded) for the result, captures it, then completes the output handshake.
  task automatic do_op(input logic [45:0] sum, output int lat, output logic [23:0] m,
                       output logic g, output logic s, output logic [5:0] lz, output logic z);
    bus.in_valid = 1'b1;
    bus.sum_in   = sum;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    lat = 0;
    while (bus.out_valid !== 1'b1 && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    m  = bus.norm_mant;
    g  = bus.guard;
    s  = bus.sticky;
    lz = bus.lz_cnt;
    z  = bus.zero;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.in_valid = 1'b0; bus.out_ready = 1'b0; bus.sum_in = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      errors++; $display("FAIL reset_handshake in_ready=%b out_valid=%b need 1/0", bus.in_ready, bus.out_valid);
    end
    checks++;
    if (bus.norm_mant !== 24'h0 || bus.guard !== 1'b0 || bus.sticky !== 1'b0 || bus.lz_cnt !== 6'd0 || bus.zero !== 1'b0) begin
      errors++; $display("FAIL reset_data mant=%h g=%b s=%b lz=%0d z=%b need all 0",
                         bus.norm_mant, bus.guard, bus.sticky, bus.lz_cnt, bus.zero);
    end
  endtask

  task automatic test_vectors();
    logic [45:0] sums [5] = '{46'h2000_0000_0000, 46'h1, 46'h2000_0020_0001, 46'h3, 46'h1FFF_FFFF_FFFF};
    logic [23:0] e_m  [5] = '{24'h800000, 24'h800000, 24'h800000, 24'hC00000, 24'hFFFFFF};
    logic        e_g  [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    logic        e_s  [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    int          e_lz [5] = '{0, 45, 0, 44, 1};
    int lat; logic [23:0] m; logic g, s, z; logic [5:0] lz;
    for (int i = 0; i < 5; i++) begin
      do_op(sums[i], lat, m, g, s, lz, z);
      checks++;
      if (lat != exp_lat(e_lz[i], 1'b0)) begin
        errors++; $display("FAIL vec%0d_latency got %0d need %0d", i, lat, exp_lat(e_lz[i], 1'b0));
      end
      checks++;
      if (m !== e_m[i] || g !== e_g[i] || s !== e_s[i] || lz !== 6'(e_lz[i]) || z !== 1'b0) begin
        errors++; $display("FAIL vec%0d_result got mant=%h g=%b s=%b lz=%0d z=%b need mant=%h g=%b s=%b lz=%0d z=0",
                           i, m, g, s, lz, z, e_m[i], e_g[i], e_s[i], e_lz[i]);
      end
    end
  endtask

  task automatic test_zero();
    int lat; logic [23:0] m; logic g, s, z; logic [5:0] lz;
    do_op(46'h0, lat, m, g, s, lz, z);
    checks++;
    if (lat != exp_lat(0, 1'b1)) begin
      errors++; $display("FAIL zero_latency got %0d need %0d", lat, exp_lat(0, 1'b1));
    end
    checks++;
    if (m !== 24'h0 || g !== 1'b0 || s !== 1'b0 || lz !== 6'd0 || z !== 1'b1) begin
      errors++; $display("FAIL zero_result got mant=%h g=%b s=%b lz=%0d z=%b need 0/0/0/0/1", m, g, s, lz, z);
    end
  endtask

  task automatic test_backpressure();
    int lat;
    bus.in_valid = 1'b1;
    bus.sum_in   = 46'h2000_0000_0000;
    @(posedge clk); #1;
    bus.sum_in   = 46'h3;   // new request held by upstream while busy
    lat = 0;
    while (bus.out_valid !== 1'b1 && lat < 200) begin
      @(posedge clk); #1; lat++;
    end
    for (int c = 0; c < 5; c++) begin
      checks++;
      if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.norm_mant !== 24'h800000 ||
          bus.guard !== 1'b0 || bus.sticky !== 1'b0 || bus.lz_cnt !== 6'd0 || bus.zero !== 1'b0) begin
        errors++; $display("FAIL hold_cycle%0d got ov=%b ir=%b mant=%h g=%b s=%b lz=%0d z=%b need 1/0/800000/0/0/0/0",
                           c, bus.out_valid, bus.in_ready, bus.norm_mant, bus.guard, bus.sticky, bus.lz_cnt, bus.zero);
      end
      @(posedge clk); #1;
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      errors++; $display("FAIL after_take ov=%b ir=%b need 0/1", bus.out_valid, bus.in_ready);
    end
    @(posedge clk); #1;   // held request accepted on this edge
    bus.in_valid = 1'b0;
    lat = 0;
    while (bus.out_valid !== 1'b1 && lat < 200) begin
      @(posedge clk); #1; lat++;
    end
    checks++;
    if (lat != exp_lat(44, 1'b0) || bus.lz_cnt !== 6'd44 || bus.norm_mant !== 24'hC00000) begin
      errors++; $display("FAIL held_request lat=%0d lz=%0d mant=%h need %0d/44/c00000",
                         lat, bus.lz_cnt, bus.norm_mant, exp_lat(44, 1'b0));
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset_mid_shift();
    int lat; int seen; logic [23:0] m; logic g, s, z; logic [5:0] lz;
    bus.in_valid = 1'b1;
    bus.sum_in   = 46'h100;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.norm_mant !== 24'h0 || bus.lz_cnt !== 6'd0 ||
        bus.guard !== 1'b0 || bus.sticky !== 1'b0 || bus.zero !== 1'b0) begin
      errors++; $display("FAIL mid_reset ov=%b ir=%b mant=%h lz=%0d g=%b s=%b z=%b need 0/1/0/0/0/0/0",
                         bus.out_valid, bus.in_ready, bus.norm_mant, bus.lz_cnt, bus.guard, bus.sticky, bus.zero);
    end
    @(posedge clk); #1 rst = 1'b0;
    seen = 0;
    for (int c = 0; c < 50; c++) begin
      @(posedge clk); #1;
      if (bus.out_valid === 1'b1) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++; $display("FAIL stale_result out_valid cycles=%0d need 0", seen);
    end
    do_op(46'h100, lat, m, g, s, lz, z);
    checks++;
    if (lz !== 6'd37 || m !== 24'h800000 || g !== 1'b0 || s !== 1'b0 || z !== 1'b0 || lat != exp_lat(37, 1'b0)) begin
      errors++; $display("FAIL post_reset_op lz=%0d mant=%h g=%b s=%b z=%b lat=%0d need 37/800000/0/0/0/%0d",
                         lz, m, g, s, z, lat, exp_lat(37, 1'b0));
    end
  endtask

  task automatic test_back_to_back();
    int lat; logic [23:0] m; logic g, s, z; logic [5:0] lz;
    do_op(46'h0000_0000_0800, lat, m, g, s, lz, z);
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      errors++; $display("FAIL b2b_idle ir=%b ov=%b need 1/0", bus.in_ready, bus.out_valid);
    end
    checks++;
    if (lz !== 6'd34 || m !== 24'h800000) begin
      errors++; $display("FAIL b2b_first lz=%0d mant=%h need 34/800000", lz, m);
    end
    do_op(46'h0C00_0000_0001, lat, m, g, s, lz, z);
    checks++;
    if (lz !== 6'd2 || m !== 24'hC00000 || g !== 1'b0 || s !== 1'b1 || lat != exp_lat(2, 1'b0)) begin
      errors++; $display("FAIL b2b_second lz=%0d mant=%h g=%b s=%b lat=%0d need 2/c00000/0/1/%0d",
                         lz, m, g, s, lat, exp_lat(2, 1'b0));
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_vectors();
    test_zero();
    test_backpressure();
    test_reset_mid_shift();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
